// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI target shifter
// Purpose: FSM state encoding, synchroniser depth and the default frame width.
// Ports: none (package).
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_tgt_state_t;

  localparam int SYNC_STAGES    = 2;
  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/spi_target_shifter_if.sv
// rtl/spi_target_shifter_if.sv - parallel TX/RX handshake bundle of the SPI target
// Purpose: groups the valid/ready TX load path and RX delivery path.
// Signals:
//   TX_DATA/TX_VALID  master -> slave  word offered for a later frame
//   TX_READY          slave -> master  holding buffer empty
//   RX_DATA/RX_VALID  slave -> master  last complete received frame
//   RX_READY          master -> slave  consumer accepts RX_DATA
// Modports: master = bridge-side logic, slave = spi_target_shifter.
interface spi_target_shifter_if
  import spi_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [DATA_W-1:0] TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;

  modport master (
    output TX_DATA, TX_VALID, RX_READY,
    input  TX_READY, RX_DATA, RX_VALID
  );

  modport slave (
    input  TX_DATA, TX_VALID, RX_READY,
    output TX_READY, RX_DATA, RX_VALID
  );

endinterface

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser with rise/fall detection
// Purpose: brings an asynchronous pin into ACLK and flags its edges. One extra
//   flop behind the synchroniser holds the previous synchronised value.
// Ports:
//   ACLK   in   system clock
//   RESTN  in   asynchronous active-low reset (chain loads RST_VAL)
//   din    in   asynchronous input pin
//   rise   out  synchronised 0->1 seen this cycle
//   fall   out  synchronised 1->0 seen this cycle
module sync_edge_det
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic ACLK,
  input  logic RESTN,
  input  logic din,
  output logic rise,
  output logic fall
);

  // chain[SYNC_STAGES-1] is the synchronised value, chain[SYNC_STAGES] its delayed copy
  logic [SYNC_STAGES:0] chain;

  always_ff @(posedge ACLK or negedge RESTN) begin
    if (!RESTN) begin
      chain <= {(SYNC_STAGES + 1){RST_VAL}};
    end else begin
      chain <= {chain[SYNC_STAGES-1:0], din};
    end
  end

  assign rise = chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES];
  assign fall = ~chain[SYNC_STAGES-1] & chain[SYNC_STAGES];

endmodule

// File: rtl/spi_target_shifter.sv
// rtl/spi_target_shifter.sv - SPI mode-0 target, oversampled on ACLK
// Purpose: deserialises MOSI frames (MSB first) into a valid/ready RX word and
//   serialises a buffered TX word onto MISO. SCLK, CS_N and MOSI are async.
// Ports:
//   ACLK, RESTN          clock, asynchronous active-low reset
//   SCLK, CS_N, MOSI     serial pins from the controller (async)
//   MISO                 serial data out, registered
//   bus (slave)          TX load / RX delivery handshakes
//   OVERRUN              pulse: completed frame dropped, RX still pending
//   UNDERRUN             pulse: frame started with the TX buffer empty
//   FRAME_ERR            pulse: CS_N released mid-frame
module spi_target_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                 ACLK,
  input  logic                 RESTN,
  input  logic                 SCLK,
  input  logic                 CS_N,
  input  logic                 MOSI,
  output logic                 MISO,
  spi_target_shifter_if.slave  bus,
  output logic                 OVERRUN,
  output logic                 UNDERRUN,
  output logic                 FRAME_ERR
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  spi_tgt_state_t    state_q, state_n;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_n;
  logic              reload_q, reload_n;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_n, tx_shift_q, tx_shift_n;
  logic              tx_full_q, tx_full_n;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_n, rx_data_q, rx_data_n;
  logic              rx_valid_q, rx_valid_n;
  logic              miso_q, miso_n;
  logic              ovr_q, ovr_n, und_q, und_n, ferr_q, ferr_n;
  logic              tx_load;
  logic [DATA_W-1:0] rx_word;

  sync_edge_det #(.RST_VAL(1'b0)) u_sclk (
    .ACLK(ACLK), .RESTN(RESTN), .din(SCLK), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_cs (
    .ACLK(ACLK), .RESTN(RESTN), .din(CS_N), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge ACLK or negedge RESTN) begin
    if (!RESTN) begin
      mosi_chain <= '0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
    end
  end
  assign mosi_s  = mosi_chain[SYNC_STAGES-1];
  assign rx_word = {rx_shift_q[DATA_W-2:0], mosi_s};

  always_ff @(posedge ACLK or negedge RESTN) begin
    if (!RESTN) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      reload_q   <= 1'b0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      reload_q   <= reload_n;
      tx_buf_q   <= tx_buf_n;
      tx_full_q  <= tx_full_n;
      tx_shift_q <= tx_shift_n;
      rx_shift_q <= rx_shift_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
      miso_q     <= miso_n;
      ovr_q      <= ovr_n;
      und_q      <= und_n;
      ferr_q     <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    reload_n   = reload_q;
    tx_buf_n   = tx_buf_q;
    tx_full_n  = tx_full_q;
    tx_shift_n = tx_shift_q;
    rx_shift_n = rx_shift_q;
    rx_data_n  = rx_data_q;
    rx_valid_n = rx_valid_q;
    miso_n     = miso_q;
    ovr_n      = 1'b0;
    und_n      = 1'b0;
    ferr_n     = 1'b0;
    tx_load    = 1'b0;

    if (rx_valid_q && bus.RX_READY) begin
      rx_valid_n = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_n   = SHIFT;
          bit_cnt_n = '0;
          reload_n  = 1'b0;
          tx_load   = 1'b1;
        end
      end
      SHIFT: begin
        // CS_N edges take priority; a coincident SCLK edge is ignored
        if (cs_rise) begin
          state_n   = IDLE;
          ferr_n    = (bit_cnt_q != '0);
          bit_cnt_n = '0;
          reload_n  = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_n = rx_word;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_n = '0;
            reload_n  = 1'b1;
            if (!rx_valid_q || bus.RX_READY) begin
              rx_data_n  = rx_word;
              rx_valid_n = 1'b1;
            end else begin
              ovr_n = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          // the fall that closes a frame opens the next one while CS_N stays low
          if (reload_q) begin
            reload_n = 1'b0;
            tx_load  = 1'b1;
          end else begin
            tx_shift_n = {tx_shift_q[DATA_W-2:0], 1'b0};
            miso_n     = tx_shift_q[DATA_W-2];
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (tx_load) begin
      if (tx_full_q) begin
        tx_shift_n = tx_buf_q;
        miso_n     = tx_buf_q[DATA_W-1];
        tx_full_n  = 1'b0;
      end else begin
        tx_shift_n = '0;
        miso_n     = 1'b0;
        und_n      = 1'b1;
      end
    end

    // a capture alongside a load only refills the buffer for the next frame
    if (bus.TX_VALID && !tx_full_q) begin
      tx_buf_n  = bus.TX_DATA;
      tx_full_n = 1'b1;
    end
  end

  assign MISO         = miso_q;
  assign OVERRUN      = ovr_q;
  assign UNDERRUN     = und_q;
  assign FRAME_ERR    = ferr_q;
  assign bus.TX_READY = ~tx_full_q;
  assign bus.RX_DATA  = rx_data_q;
  assign bus.RX_VALID = rx_valid_q;

endmodule

// File: tb/tb_spi_target_shifter.sv
// tb/tb_spi_target_shifter.sv - self-checking bench for spi_target_shifter
module tb_spi_target_shifter;

  localparam int DW = 8;

  logic ACLK, RESTN, SCLK, CS_N, MOSI, MISO, OVERRUN, UNDERRUN, FRAME_ERR;

  spi_target_shifter_if #(.DATA_W(DW)) bus ();

  spi_target_shifter #(.DATA_W(DW)) dut (
    .ACLK(ACLK), .RESTN(RESTN), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO),
    .bus(bus), .OVERRUN(OVERRUN), .UNDERRUN(UNDERRUN), .FRAME_ERR(FRAME_ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // transaction-level reference: one-word TX buffer, one-word RX holding slot
  bit         m_tx_full;
  logic [7:0] m_tx_buf;
  bit         m_rx_pending;
  logic [7:0] m_rx_data;
  logic [7:0] exp_acc_q[$];
  int exp_ovr, exp_und, exp_ferr;
  int obs_ovr, obs_und, obs_ferr;

  logic [7:0] b_mw[4];
  bit         b_pe[4];
  logic [7:0] b_pw[4];
  logic [7:0] last_miso[4];
  logic [7:0] cmp_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge ACLK) begin
    if (RESTN === 1'b1) begin
      if (bus.RX_VALID === 1'b1 && bus.RX_READY === 1'b1) begin
        if (exp_acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_accept actual=%0h required=no word", bus.RX_DATA);
        end else begin
          cmp_exp = exp_acc_q.pop_front();
          chk("rx_accept", 32'(bus.RX_DATA), 32'(cmp_exp));
        end
      end
      if (OVERRUN === 1'b1)   obs_ovr++;
      if (UNDERRUN === 1'b1)  obs_und++;
      if (FRAME_ERR === 1'b1) obs_ferr++;
    end
  end

  task automatic model_rx_done(input logic [7:0] w);
    if (bus.RX_READY) begin
      exp_acc_q.push_back(w);
      m_rx_data = w;
    end else if (m_rx_pending) begin
      exp_ovr++;
    end else begin
      m_rx_pending = 1'b1;
      m_rx_data    = w;
    end
  endtask

  task automatic set_ready(input bit r);
    if (r && m_rx_pending) begin
      exp_acc_q.push_back(m_rx_data);
      m_rx_pending = 1'b0;
    end
    bus.RX_READY = r;
    #10;
  endtask

  task automatic tx_push(input logic [7:0] w);
    chk("tx_ready_before_push", 32'(bus.TX_READY), 32'(!m_tx_full));
    bus.TX_DATA  = w;
    bus.TX_VALID = 1'b1;
    #10;
    bus.TX_VALID = 1'b0;
    if (!m_tx_full) begin
      m_tx_full = 1'b1;
      m_tx_buf  = w;
    end
  endtask

  task automatic burst(input int nfr, input int last_bits);
    logic [7:0] exp_m, got_m;
    int nb;
    CS_N = 1'b0;
    #60;
    for (int f = 0; f < nfr; f++) begin
      if (m_tx_full) begin
        exp_m     = m_tx_buf;
        m_tx_full = 1'b0;
      end else begin
        exp_m = 8'h00;
        exp_und++;
      end
      got_m = 8'h00;
      nb = (f == nfr - 1) ? last_bits : 8;
      for (int i = 0; i < nb; i++) begin
        MOSI = b_mw[f][7-i];
        #50;
        SCLK  = 1'b1;
        got_m = {got_m[6:0], MISO};
        if (i == 7) model_rx_done(b_mw[f]);
        if (i == 2 && b_pe[f]) begin
          tx_push(b_pw[f]);
          #40;
        end else begin
          #50;
        end
        if (!(f == nfr - 1 && i == nb - 1)) SCLK = 1'b0;
      end
      chk("miso_frame", 32'(got_m), 32'(exp_m >> (8 - nb)));
      last_miso[f] = got_m;
      if (nb < 8) exp_ferr++;
    end
    CS_N = 1'b1;
    #30;
    SCLK = 1'b0;
    MOSI = 1'b0;
    #120;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_tx_ready"}, 32'(bus.TX_READY), 32'(!m_tx_full));
    chk({tag, "_rx_valid"}, 32'(bus.RX_VALID), 32'(m_rx_pending));
    chk({tag, "_rx_data"},  32'(bus.RX_DATA),  32'(m_rx_data));
    chk({tag, "_overrun_cnt"},  32'(obs_ovr),  32'(exp_ovr));
    chk({tag, "_underrun_cnt"}, 32'(obs_und),  32'(exp_und));
    chk({tag, "_frame_err_cnt"}, 32'(obs_ferr), 32'(exp_ferr));
  endtask

  task automatic set_frames(input logic [7:0] w0, input logic [7:0] w1, input bit pe0,
                            input logic [7:0] pw0);
    b_mw[0] = w0; b_mw[1] = w1; b_mw[2] = 8'h00; b_mw[3] = 8'h00;
    b_pe[0] = pe0; b_pe[1] = 1'b0; b_pe[2] = 1'b0; b_pe[3] = 1'b0;
    b_pw[0] = pw0; b_pw[1] = 8'h00; b_pw[2] = 8'h00; b_pw[3] = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, nfr, lb;
    RESTN = 1'b0; SCLK = 1'b0; CS_N = 1'b1; MOSI = 1'b0;
    bus.TX_DATA = 8'h00; bus.TX_VALID = 1'b0; bus.RX_READY = 1'b0;
    m_tx_full = 1'b0; m_tx_buf = 8'h00; m_rx_pending = 1'b0; m_rx_data = 8'h00;
    exp_ovr = 0; exp_und = 0; exp_ferr = 0; obs_ovr = 0; obs_und = 0; obs_ferr = 0;
    @(posedge ACLK);
    #2;
    chk("rst_miso", 32'(MISO), 32'h0);
    chk("rst_tx_ready", 32'(bus.TX_READY), 32'h1);
    chk("rst_rx_valid", 32'(bus.RX_VALID), 32'h0);
    chk("rst_rx_data", 32'(bus.RX_DATA), 32'h0);
    chk("rst_pulses", 32'({OVERRUN, UNDERRUN, FRAME_ERR}), 32'h0);
    #20;
    RESTN = 1'b1;
    #30;

    // 1: basic frame
    tx_push(8'hA5);
    set_frames(8'h3C, 8'h00, 1'b0, 8'h00);
    burst(1, 8);
    chk("t1_miso", 32'(last_miso[0]), 32'hA5);
    chk("t1_rx_data", 32'(bus.RX_DATA), 32'h3C);
    chk("t1_rx_valid", 32'(bus.RX_VALID), 32'h1);
    chk("t1_tx_ready", 32'(bus.TX_READY), 32'h1);
    check_state("t1");

    // 3: overrun while RX pending
    s0 = obs_ovr;
    set_frames(8'h55, 8'h00, 1'b0, 8'h00);
    burst(1, 8);
    chk("t3_overrun_once", 32'(obs_ovr - s0), 32'h1);
    chk("t3_rx_kept", 32'(bus.RX_DATA), 32'h3C);
    check_state("t3");
    set_ready(1'b1);
    #30;
    check_state("t3_drain");

    // 2: back-to-back frames with CS_N held low
    tx_push(8'h81);
    set_frames(8'h11, 8'h22, 1'b1, 8'h7E);
    burst(2, 8);
    chk("t2_miso0", 32'(last_miso[0]), 32'h81);
    chk("t2_miso1", 32'(last_miso[1]), 32'h7E);
    chk("t2_rx_last", 32'(bus.RX_DATA), 32'h22);
    check_state("t2");

    // 5: underrun
    s0 = obs_und;
    set_frames(8'hC3, 8'h00, 1'b0, 8'h00);
    burst(1, 8);
    chk("t5_miso_zero", 32'(last_miso[0]), 32'h0);
    chk("t5_underrun_once", 32'(obs_und - s0), 32'h1);
    check_state("t5");

    // 4: CS_N rises after 5 bits
    set_ready(1'b0);
    tx_push(8'h5A);
    set_frames(8'h99, 8'h00, 1'b0, 8'h00);
    burst(1, 8);
    s0 = obs_ferr;
    set_frames(8'hF0, 8'h00, 1'b0, 8'h00);
    burst(1, 5);
    chk("t4_frame_err_once", 32'(obs_ferr - s0), 32'h1);
    chk("t4_rx_valid_kept", 32'(bus.RX_VALID), 32'h1);
    chk("t4_rx_data_kept", 32'(bus.RX_DATA), 32'h99);
    set_ready(1'b1);
    tx_push(8'h3D);
    set_frames(8'h66, 8'h00, 1'b0, 8'h00);
    burst(1, 8);
    chk("t4_next_miso", 32'(last_miso[0]), 32'h3D);
    chk("t4_next_rx", 32'(bus.RX_DATA), 32'h66);
    check_state("t4");

    // 6: asynchronous reset mid-frame
    set_ready(1'b0);
    set_frames(8'h12, 8'h00, 1'b0, 8'h00);
    burst(1, 8);
    tx_push(8'hFF);
    CS_N = 1'b0;
    m_tx_full = 1'b0;
    #60;
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1;
      #50;
      SCLK = 1'b1;
      #50;
      SCLK = 1'b0;
    end
    #30;
    chk("t6_miso_pre", 32'(MISO), 32'h1);
    chk("t6_rx_valid_pre", 32'(bus.RX_VALID), 32'h1);
    #1;
    RESTN = 1'b0;
    #1;
    chk("t6_miso", 32'(MISO), 32'h0);
    chk("t6_tx_ready", 32'(bus.TX_READY), 32'h1);
    chk("t6_rx_valid", 32'(bus.RX_VALID), 32'h0);
    chk("t6_rx_data", 32'(bus.RX_DATA), 32'h0);
    chk("t6_pulses", 32'({OVERRUN, UNDERRUN, FRAME_ERR}), 32'h0);
    CS_N = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    #8;
    RESTN = 1'b1;
    m_tx_full = 1'b0; m_rx_pending = 1'b0; m_rx_data = 8'h00;
    exp_acc_q.delete();
    #20;
    set_ready(1'b1);
    tx_push(8'hC6);
    set_frames(8'h3A, 8'h00, 1'b0, 8'h00);
    burst(1, 8);
    chk("t6_after_miso", 32'(last_miso[0]), 32'hC6);
    chk("t6_after_rx", 32'(bus.RX_DATA), 32'h3A);
    check_state("t6");

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      set_ready($urandom_range(0, 3) != 0);
      if (!m_tx_full && $urandom_range(0, 3) != 0) tx_push(8'($urandom));
      nfr = $urandom_range(1, 3);
      lb  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
      for (int f = 0; f < 4; f++) begin
        b_mw[f] = 8'($urandom);
        b_pe[f] = ($urandom_range(0, 1) == 1);
        b_pw[f] = 8'($urandom);
      end
      burst(nfr, lb);
      check_state("rand");
    end

    set_ready(1'b1);
    #60;
    chk("final_rx_queue_empty", 32'(exp_acc_q.size()), 32'h0);
    check_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
